// File: rtl/avr_io_in_pkg.sv
// Shared constants and edge-selection helper for the avr_io_in input port.
package avr_io_in_pkg;
  `include "avr_io_in_defs.vh"

  function automatic logic [7:0] edge_gate(input logic [7:0] rise, input logic [7:0] fall,
                                           input logic [1:0] sel);
    case (sel)
      EDGE_RISE:               return rise;
      EDGE_FALL:               return fall;
      EDGE_BOTH, EDGE_BOTH_ALT: return rise | fall;
      default:                 return rise | fall;
    endcase
  endfunction
endpackage

// File: rtl/avr_io_in_if.sv
// IO-bus connection between the AVR core (master) and the input port (slave).
interface avr_io_in_if;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;

  modport master (output io_re, output io_we, output io_a, output io_do, input io_di);
  modport slave  (input io_re, input io_we, input io_a, input io_do, output io_di);
endinterface

// File: rtl/avr_io_in_debounce.sv
// One pin's debounce: tick-driven persistence counter plus stable flop.
// With AVR_IO_IN_DEBOUNCE_EN undefined the stable flop just follows the synchronised pin.
module avr_io_in_debounce #(
  parameter int   DEB_CNT = 4,
  parameter logic PIN_RST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync_in,
  output logic stable
);

`ifdef AVR_IO_IN_DEBOUNCE_EN
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= PIN_RST;
    end else if (tick) begin
      if (sync_in != stable) begin
        // The DEB_CNT-th consecutive differing tick commits the new value.
        if (cnt == 4'(DEB_CNT - 1)) begin
          stable <= sync_in;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  localparam int unused_deb_cnt = DEB_CNT;
  logic unused_tick;
  assign unused_tick = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable <= PIN_RST;
    else        stable <= sync_in;
  end
`endif

endmodule

// File: rtl/avr_io_in_defs.vh
// Register map, CTRL field layout and EDGE encodings for the avr_io_in responder.
`ifndef AVR_IO_IN_DEFS_VH
`define AVR_IO_IN_DEFS_VH

localparam logic [1:0] REG_PIN  = 2'd0;
localparam logic [1:0] REG_FLAG = 2'd1;
localparam logic [1:0] REG_MASK = 2'd2;
localparam logic [1:0] REG_CTRL = 2'd3;

localparam int CTRL_PRESC_LSB = 0;
localparam int CTRL_PRESC_W   = 4;
localparam int CTRL_EDGE_LSB  = 4;
localparam int CTRL_EDGE_W    = 2;

localparam logic [1:0] EDGE_BOTH     = 2'b00;
localparam logic [1:0] EDGE_RISE     = 2'b01;
localparam logic [1:0] EDGE_FALL     = 2'b10;
localparam logic [1:0] EDGE_BOTH_ALT = 2'b11;

`endif

// File: rtl/avr_io_in.sv
// AVR IO-bus input port: 2-flop sync, optional debounce (AVR_IO_IN_DEBOUNCE_EN),
// edge flags with W1C, mask and level irq. Registers: PIN, FLAG, MASK, CTRL.
module avr_io_in
  import avr_io_in_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEB_CNT   = 4,
  parameter logic [7:0] PIN_RESET = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  avr_io_in_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic             irq
);

  logic [WIDTH-1:0]       sync_p0, sync_p1, stable, stable_d;
  logic [WIDTH-1:0]       flag, mask, rise, fall, new_edge, w1c;
  logic [CTRL_EDGE_W-1:0] edge_sel;
  logic [7:0]             edge_all, rd;
  logic                   tick, wr_flag, wr_mask, wr_ctrl;

  assign wr_flag = bus.io_we && (bus.io_a == REG_FLAG);
  assign wr_mask = bus.io_we && (bus.io_a == REG_MASK);
  assign wr_ctrl = bus.io_we && (bus.io_a == REG_CTRL);

`ifdef AVR_IO_IN_DEBOUNCE_EN
  logic [CTRL_PRESC_W-1:0] presc;
  logic [15:0]             tick_cnt, tick_max;

  assign tick_max = (16'd1 << presc) - 16'd1;
  assign tick     = (tick_cnt == tick_max);

  // A CTRL write restarts the prescaler so the first tick is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      presc    <= '0;
    end else if (wr_ctrl) begin
      tick_cnt <= '0;
      presc    <= bus.io_do[CTRL_PRESC_LSB +: CTRL_PRESC_W];
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Stage p0/p1: two-flop synchroniser on the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pin_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    avr_io_in_debounce #(
      .DEB_CNT (DEB_CNT),
      .PIN_RST (PIN_RESET[i])
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .sync_in (sync_p1[i]),
      .stable  (stable[i])
    );
  end

  assign rise     = stable & ~stable_d;
  assign fall     = ~stable & stable_d;
  assign edge_all = edge_gate(8'(rise), 8'(fall), edge_sel);
  assign new_edge = edge_all[WIDTH-1:0];
  assign w1c      = wr_flag ? bus.io_do[WIDTH-1:0] : '0;

  // Edge stage: flags set the clock after stable moves; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= PIN_RESET[WIDTH-1:0];
      flag     <= '0;
      mask     <= '0;
      edge_sel <= '0;
    end else begin
      stable_d <= stable;
      flag     <= (flag & ~w1c) | new_edge;
      if (wr_mask) mask     <= bus.io_do[WIDTH-1:0];
      if (wr_ctrl) edge_sel <= bus.io_do[CTRL_EDGE_LSB +: CTRL_EDGE_W];
    end
  end

  assign irq = |(flag & mask);

  always_comb begin
    rd = 8'h00;
    if (bus.io_re) begin
      case (bus.io_a)
        REG_PIN:  rd[WIDTH-1:0] = stable;
        REG_FLAG: rd[WIDTH-1:0] = flag;
        REG_MASK: rd[WIDTH-1:0] = mask;
        REG_CTRL: begin
          rd[CTRL_EDGE_LSB +: CTRL_EDGE_W] = edge_sel;
`ifdef AVR_IO_IN_DEBOUNCE_EN
          rd[CTRL_PRESC_LSB +: CTRL_PRESC_W] = presc;
`endif
        end
        default: rd = 8'h00;
      endcase
    end
  end

  assign bus.io_di = rd;

endmodule

// File: tb/tb_avr_io_in.sv
// Directed self-checking bench for avr_io_in; covers both AVR_IO_IN_DEBOUNCE_EN builds.
module tb_avr_io_in;
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] pin_in = 8'h00;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

`ifdef AVR_IO_IN_DEBOUNCE_EN
  localparam int FLAG_LAT = 7;
`else
  localparam int FLAG_LAT = 4;
`endif

  avr_io_in_if bus ();

  avr_io_in #(
    .WIDTH     (8),
    .DEB_CNT   (4),
    .PIN_RESET (8'h00)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pin_in (pin_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus.io_a  = a;
    bus.io_re = 1'b1;
    #1;
    d = bus.io_di;
    bus.io_re = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    peek(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_we = 1'b1;
    bus.io_a  = a;
    bus.io_do = d;
    @(negedge clk);
    bus.io_we = 1'b0;
  endtask

  task automatic settle(input logic [7:0] v);
    logic [7:0] d;
    int n;
    n = 0;
    d = ~v;
    pin_in = v;
    while (d != v && n < 80) begin
      @(negedge clk);
      peek(2'd0, d);
      n++;
    end
    check_val("settle", d, v);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.io_re = 1'b0;
    bus.io_we = 1'b0;
    bus.io_a  = 2'd0;
    bus.io_do = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_reg("rst_pin",  2'd0, 8'h00);
    expect_reg("rst_flag", 2'd1, 8'h00);
    expect_reg("rst_mask", 2'd2, 8'h00);
    expect_reg("rst_ctrl", 2'd3, 8'h00);
    check_val("rst_irq", {7'b0, irq}, 8'h00);
    bus.io_a = 2'd2;
    #1 check_val("idle_di", bus.io_di, 8'h00);

`ifdef AVR_IO_IN_DEBOUNCE_EN
    // PRESC=2: ticks at W+4,8,12,16 after the CTRL write, so PIN moves 16 clocks later
    write_reg(2'd3, 8'h02);
    pin_in = 8'h01;
    repeat (15) @(negedge clk);
    expect_reg("deb_early", 2'd0, 8'h00);
    @(negedge clk);
    expect_reg("deb_pin", 2'd0, 8'h01);
    @(negedge clk);
    expect_reg("deb_flag", 2'd1, 8'h01);
    check_val("irq_unmasked", {7'b0, irq}, 8'h00);
    write_reg(2'd2, 8'h01);
    check_val("irq_masked_in", {7'b0, irq}, 8'h01);

    write_reg(2'd3, 8'h00);
    write_reg(2'd1, 8'hFF);
    @(negedge clk);
    pin_in = 8'h09;
    repeat (3) @(negedge clk);
    pin_in = 8'h01;
    repeat (10) @(negedge clk);
    expect_reg("glitch_pin", 2'd0, 8'h01);
    expect_reg("glitch_flag", 2'd1, 8'h00);
    pin_in = 8'h09;
    repeat (10) @(negedge clk);
    expect_reg("hold_pin", 2'd0, 8'h09);
    expect_reg("hold_flag", 2'd1, 8'h08);
    write_reg(2'd2, 8'h00);
    settle(8'h00);
    write_reg(2'd1, 8'hFF);
    expect_reg("clr_flag", 2'd1, 8'h00);
`else
    @(negedge clk);
    pin_in = 8'hA5;
    repeat (2) @(negedge clk);
    expect_reg("lat2_pin", 2'd0, 8'h00);
    @(negedge clk);
    expect_reg("lat3_pin", 2'd0, 8'hA5);
    expect_reg("lat3_flag", 2'd1, 8'h00);
    @(negedge clk);
    expect_reg("lat4_flag", 2'd1, 8'hA5);
    bus.io_a = 2'd0;
    #1 check_val("idle_di_pin", bus.io_di, 8'h00);
    write_reg(2'd3, 8'hFF);
    expect_reg("ctrl_ff", 2'd3, 8'h30);
    write_reg(2'd3, 8'h00);
    settle(8'h00);
    write_reg(2'd1, 8'hFF);
    expect_reg("clr_flag", 2'd1, 8'h00);
`endif

    // Edge selection
    write_reg(2'd3, 8'h10);
    settle(8'h02);
    expect_reg("rise_up", 2'd1, 8'h02);
    write_reg(2'd1, 8'hFF);
    settle(8'h00);
    expect_reg("rise_down", 2'd1, 8'h00);
    write_reg(2'd3, 8'h20);
    expect_reg("ctrl_20", 2'd3, 8'h20);
    settle(8'h02);
    expect_reg("fall_up", 2'd1, 8'h00);
    settle(8'h00);
    expect_reg("fall_down", 2'd1, 8'h02);
    write_reg(2'd1, 8'hFF);

    // W1C and irq
    write_reg(2'd3, 8'h00);
    settle(8'h03);
    expect_reg("flag_03", 2'd1, 8'h03);
    write_reg(2'd2, 8'h03);
    check_val("irq_03", {7'b0, irq}, 8'h01);
    write_reg(2'd1, 8'h01);
    expect_reg("w1c_01", 2'd1, 8'h02);
    check_val("irq_02", {7'b0, irq}, 8'h01);
    write_reg(2'd1, 8'h02);
    expect_reg("w1c_02", 2'd1, 8'h00);
    check_val("irq_clr", {7'b0, irq}, 8'h00);

    // Clear of bit 2 lands on the same edge as a new falling edge on bit 2
    settle(8'h07);
    expect_reg("flag_04", 2'd1, 8'h04);
    @(negedge clk);
    pin_in = 8'h03;
    repeat (FLAG_LAT - 1) @(negedge clk);
    bus.io_we = 1'b1;
    bus.io_a  = 2'd1;
    bus.io_do = 8'h04;
    @(negedge clk);
    bus.io_we = 1'b0;
    expect_reg("w1c_vs_set", 2'd1, 8'h04);
    check_val("irq_off_mask", {7'b0, irq}, 8'h00);
    write_reg(2'd2, 8'h04);
    check_val("irq_unmask", {7'b0, irq}, 8'h01);
    write_reg(2'd2, 8'h00);
    check_val("irq_remask", {7'b0, irq}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avr_io_in.md
Name: avr_io_in

Overview:
- IO-bus responder: the input-direction counterpart of the output port peripheral. Samples external pins (buttons/switches) into the AVR core.
- Synchronises and debounces each pin, latches selected edges into flags, and raises a level interrupt into the priority encoder.
- Occupies a 4-register window, selected at top level by io_a[5:2]; sees only io_a[1:0].

Parameters:
- WIDTH, 8, number of input pins (1..8); unused read bits return 0.
- DEB_CNT, 4, consecutive debounce ticks a changed sample must persist before the stable value updates (1..15).
- PIN_RESET, 8'h00, stable-value reset state (low WIDTH bits used).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- io_re  input  1  read strobe, already qualified by block select.
- io_we  input  1  write strobe, already qualified by block select.
- io_a  input  2  register address.
- io_di  output  8  read data to core; wired-OR bus, drives 8'h00 when io_re=0.
- io_do  input  8  write data from core.
- pin_in  input  WIDTH  asynchronous external pins.
- irq  output  1  level interrupt = |(FLAG & MASK).

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - sync regs = 0; stable = PIN_RESET; FLAG = 0; MASK = 0; CTRL = 0; tick counter = 0; per-bit debounce counters = 0; irq = 0; io_di = 0.
- Register map:
  - 0 PIN: R stable value; writes ignored.
  - 1 FLAG: R pending edges; W1C, bits written 1 clear.
  - 2 MASK: R/W.
  - 3 CTRL: [3:0] PRESC, [5:4] EDGE, [7:6] read 0.
- Read path: combinational. io_di = selected register when io_re, else 0. No side effects on read.
- Write path: takes effect on the clk edge where io_we=1.
- Synchroniser: 2-flop per bit.
- Tick generator: free-running counter; tick asserts one cycle every 2^PRESC clocks (PRESC=0 gives a tick every clock). A CTRL write restarts the counter at 0.
- Per-bit debounce, evaluated on tick only:
  - If sync != stable, counter++. When counter reaches DEB_CNT, stable <= sync and counter <= 0.
  - If sync == stable, counter <= 0.
  - A glitch shorter than DEB_CNT ticks never changes stable.
- Latency, pin change to PIN update: 2 clk sync + DEB_CNT ticks + at most one tick phase.
- Edge detect on stable, registered: rising = stable & ~stable_d, falling = ~stable & stable_d.
  - EDGE=00 or 11: both edges set flags; 01: rising only; 10: falling only.
  - Flag sets the clock after stable changes.
- FLAG update rule: FLAG <= (FLAG & ~w1c) | new_edge. On the same bit in the same cycle, set wins over clear.
- MASK does not gate flag setting, only irq. Masking a pending flag drops irq the next cycle; unmasking raises it.
- irq: combinational from registered FLAG/MASK. Stays high until the ISR W1C-clears the flags. No ack port.
- A stable change away from PIN_RESET after reset produces a normal edge flag.
- Reset mid-debounce: all state discarded immediately.

Optional Feature:
- Macro: AVR_IO_IN_DEBOUNCE_EN.
- Defined: debounce as above.
- Undefined:
  - stable <= sync every clock, 3 clk pin-to-PIN latency.
  - Tick counter and per-bit counters are removed.
  - CTRL[3:0] reads 0 and ignores writes; CTRL[5:4] behaves unchanged.

Decomposition:
- Shared include avr_io_in_defs.vh holds:
  - register addresses REG_PIN=0, REG_FLAG=1, REG_MASK=2, REG_CTRL=3;
  - CTRL field positions/widths (PRESC [3:0], EDGE [5:4]);
  - EDGE encodings.
- Sub-module avr_io_in_debounce: one bit's counter, stable flop and tick input. Instantiated WIDTH times via generate.

Test Plan:
- Reset, then read all four registers -> PIN=8'h00, FLAG=0, MASK=0, CTRL=0, irq=0; io_di=0 whenever io_re=0.
- PRESC=2, DEB_CNT=4; pin_in[0] 0->1 held -> PIN[0]=1 within 2+4*4+4 clk; FLAG=8'h01; irq=0 until MASK=8'h01, then irq=1 next clk.
- PRESC=0; pulse pin_in[3] high for 3 clk -> PIN and FLAG unchanged. Hold 10 clk -> PIN[3]=1, FLAG[3]=1.
- EDGE=01; toggle pin_in[1] up then down (debounced) -> FLAG=8'h02 after rising only. EDGE=10 -> only the falling edge flags.
- FLAG=8'h03, MASK=8'h03; write 8'h01 to FLAG -> FLAG=8'h02, irq stays 1; write 8'h02 -> irq=0. W1C on bit 2 in the same cycle as a new bit-2 edge -> FLAG[2]=1.
- With AVR_IO_IN_DEBOUNCE_EN undefined: pin_in=8'hA5 -> PIN=8'hA5 exactly 3 clk later; write CTRL=8'hFF -> reads 8'h30.
